// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: UART byte stream -> instruction memory writes.
// Holds the core in reset until a complete, checksum-valid image is written.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h8000,
  parameter int          MAX_WORDS = 16384,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_reset_n,
  output logic        done,
  output logic        error,
  output logic [14:0] words_written
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   len_q, len_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wr_en_d, core_reset_n_d, done_d, error_d;
  logic [31:0]   wr_addr_d, wr_data_d;
  logic [14:0]   words_written_d;
  logic [31:0]   assembled;
  logic          loading;

  // Bytes arrive little-endian, so each new byte lands in the top lane.
  assign assembled = {rx_data, shift_q};
  assign loading   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

  always_comb begin
    state_d         = state_q;
    shift_d         = shift_q;
    len_d           = len_q;
    idx_d           = idx_q;
    csum_d          = csum_q;
    tmo_d           = tmo_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr;
    wr_data_d       = wr_data;
    core_reset_n_d  = core_reset_n;
    done_d          = done;
    error_d         = error;
    words_written_d = words_written;

    if (loading) tmo_d = rx_valid ? '0 : tmo_q + 1'b1;

    case (state_q)
      S_SYNC, S_ERR: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d         = S_LEN;
          csum_d          = '0;
          idx_d           = '0;
          tmo_d           = '0;
          words_written_d = '0;
          wr_addr_d       = BASE_ADDR;
          error_d         = 1'b0;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          shift_d = assembled[31:8];
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            len_d = assembled;
            if (assembled == 32'd0 || assembled > 32'(MAX_WORDS)) begin
              state_d = S_ERR;
              error_d = 1'b1;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          shift_d = assembled[31:8];
          csum_d  = csum_q ^ rx_data;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wr_en_d         = 1'b1;
            wr_data_d       = assembled;
            wr_addr_d       = BASE_ADDR + {15'd0, words_written, 2'b00};
            words_written_d = words_written + 15'd1;
            if (32'(words_written) + 32'd1 == len_q) state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d        = S_DONE;
            done_d         = 1'b1;
            core_reset_n_d = 1'b1;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A byte arriving in the expiry cycle keeps the load alive.
    if (loading && !rx_valid && tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = S_ERR;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_SYNC;
      shift_q       <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      csum_q        <= '0;
      tmo_q         <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= BASE_ADDR;
      wr_data       <= '0;
      core_reset_n  <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      csum_q        <= csum_d;
      tmo_q         <= tmo_d;
      wr_en         <= wr_en_d;
      wr_addr       <= wr_addr_d;
      wr_data       <= wr_data_d;
      core_reset_n  <= core_reset_n_d;
      done          <= done_d;
      error         <= error_d;
      words_written <= words_written_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed byte streams.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        core_reset_n;
  logic        done;
  logic        error;
  logic [14:0] words_written;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  imem_loader #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset_n(core_reset_n), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected write addr=%h data=%h", wr_addr, wr_data);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                   wr_addr, wr_data, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic expect_normal_writes();
    sb.push_back({32'h0000_8000, 32'h0000_0013});
    sb.push_back({32'h0000_8004, 32'h0010_0093});
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, wr_addr, 32'h8000);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  task automatic check_loaded(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_core_reset_n"}, 32'(core_reset_n), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_words"}, 32'(words_written), 32'd2);
  endtask

  bq_t normal_img  = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                       8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
  bq_t bad_csum    = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                       8'h93, 8'h00, 8'h10, 8'h00, 8'h91};
  bq_t len_zero    = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
  bq_t len_big     = '{8'h01, 8'h40, 8'h00, 8'h00};
  bq_t garbage     = '{8'h00, 8'hFF, 8'h12};
  bq_t partial_tmo = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
  bq_t partial_rst = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
  bq_t sync_only   = '{8'hA5};

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Normal load, then trailing bytes in DONE must be ignored.
    expect_normal_writes();
    send_seq(normal_img);
    check_loaded("normal");
    send_seq(partial_tmo);
    idle(20);
    check_loaded("done_hold");
    chk("normal_sb_empty", 32'(sb.size()), 32'd0);

    // Bad checksum: both words written, then error.
    do_reset();
    expect_normal_writes();
    send_seq(bad_csum);
    chk("badcs_error", 32'(error), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_core_reset_n", 32'(core_reset_n), 32'd0);
    chk("badcs_words", 32'(words_written), 32'd2);
    chk("badcs_sb_empty", 32'(sb.size()), 32'd0);

    // Bad lengths, restarted from ERR by a sync byte.
    send_seq(len_zero);
    chk("len0_error", 32'(error), 32'd1);
    chk("len0_words", 32'(words_written), 32'd0);
    send_seq(sync_only);
    chk("resync_error_clear", 32'(error), 32'd0);
    send_seq(len_big);
    chk("lenbig_error", 32'(error), 32'd1);
    chk("lenbig_done", 32'(done), 32'd0);

    // Garbage before sync changes nothing.
    do_reset();
    send_seq(garbage);
    idle(2);
    check_reset_values("garbage");
    expect_normal_writes();
    send_seq(normal_img);
    check_loaded("garbage_load");

    // Timeout 16 cycles after the last byte, then recovery.
    do_reset();
    send_seq(partial_tmo);
    idle(15);
    chk("tmo_error_early", 32'(error), 32'd0);
    idle(1);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_core_reset_n", 32'(core_reset_n), 32'd0);
    expect_normal_writes();
    send_seq(normal_img);
    check_loaded("tmo_recover");

    // Reset mid-DATA, then a full load from the base address again.
    do_reset();
    send_seq(partial_rst);
    do_reset();
    check_reset_values("midreset");
    expect_normal_writes();
    send_seq(normal_img);
    check_loaded("midreset_load");

    idle(4);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
